uart_mult_byte_tx: RTL and testbench
====================================

Name: uart_mult_byte_tx

Overview:
Multi-byte UART packet transmitter. It is the transmit-side counterpart of uart_mult_byte_rx. On a start request it latches up to _MAX_BYTES payload bytes and serialises one frame on uart_txd, LSB-first 8N1: header byte, the payload, then a CRC-8 trailer. It sits in the clk_50M domain and is driven by the protocol/response logic.

Parameters:
CLK_FREQ, 50_000_000, sys_clk frequency in Hz
UART_BPS, 115200, baud rate; bit period BPS_CNT = CLK_FREQ/UART_BPS (integer divide, 434 at defaults)
_MAX_BYTES, 11, maximum payload bytes per frame
_HEADER, 8'hA5, frame header byte

Ports:
sys_clk  input  1  system clock (clk_50M); the block has one clock
sys_rst_n  input  1  asynchronous, active-low reset
tx_start  input  1  one-cycle request to send a frame
tx_len  input  4  payload byte count, 0.._MAX_BYTES
tx_payload  input  _MAX_BYTES*8  payload; byte k sits at bits [8k+7:8k]; byte 0 is sent first
tx_busy  output  1  high from the accepted request until the frame completes
tx_done  output  1  one-cycle pulse when the final stop bit completes
tx_crc  output  8  CRC of the last frame, valid when tx_done pulses
uart_txd  output  1  serial line, idles high

Behaviour:
- Reset values (asynchronous): uart_txd=1, tx_busy=0, tx_done=0, tx_crc=0, FSM=IDLE, all counters 0.
- Request acceptance:
  - tx_start is sampled only in IDLE.
  - In IDLE, tx_start at edge N latches tx_payload, tx_len and clears the CRC.
  - tx_busy=1 and uart_txd=0 (start bit of header) from edge N+1.
  - tx_start while busy is ignored and is not queued.
- Length: tx_len is clamped to _MAX_BYTES when it is larger.
- Frame:
  - Byte sequence is _HEADER, payload[0..len-1], CRC, i.e. len+2 bytes.
  - Bytes are sent back-to-back with no idle gap between a stop bit and the next start bit.
  - len=0 sends header plus CRC 0x00.
- FSM states: IDLE -> START (1 bit period, txd=0) -> DATA (8 bit periods, LSB first) -> STOP (1 bit period, txd=1).
  - From STOP: go to START if bytes remain, else go to DONE.
  - DONE lasts one cycle: tx_done=1, tx_busy=0, then IDLE.
- Bit timing:
  - A bit counter runs 0..BPS_CNT-1; each bit is held exactly BPS_CNT cycles.
  - Total frame = (len+2)*10*BPS_CNT cycles from edge N+1 to the last stop bit end.
  - tx_done is high in the following cycle.
- CRC:
  - CRC-8, polynomial x^8+x^2+x+1 (0x07), init 0x00, no reflection, no final XOR.
  - Computed over payload bytes only, not the header.
  - Update one byte per payload byte (a combinational byte-wise update is acceptable) before that byte's successor is needed.
  - tx_crc holds the final value from DONE until the next accepted request.
- Byte select: the payload byte is selected by an index counter 0..len-1. The shift register loads on entry to START.
- Reset mid-frame: uart_txd returns to 1 immediately and tx_busy drops. No tx_done is generated and the frame is abandoned. The next frame requires a new tx_start after reset release.
- Request in the DONE cycle: tx_start asserted in the DONE cycle is ignored. Accepted requests are those seen in IDLE only.

Test Plan:
- Reset/idle: hold sys_rst_n low, release, run 1000 cycles with no tx_start -> uart_txd=1, tx_busy=0, tx_done never pulses.
- Basic frame: tx_len=2, payload bytes 0x01,0x02 -> line decodes A5 01 02 1B; tx_crc=0x1B; tx_done pulses once, 4*10*434 cycles after the start bit.
- CRC check value: tx_len=9, bytes 0x31..0x39 ("123456789") -> trailer 0xF4. Also tx_len=0 -> frame A5 00, tx_busy high for exactly 20*434 cycles.
- Busy rejection and clamp:
  - Pulse tx_start again mid-frame with different data -> the first frame is unaltered and no second frame follows.
  - tx_len=15 -> exactly 11 payload bytes are sent.
- Reset mid-frame: assert sys_rst_n low during DATA of payload byte 1 -> uart_txd=1 the same instant, tx_busy=0, no tx_done. A new request after release sends a complete correct frame.
- Back-to-back: issue tx_start the cycle after tx_done -> the second frame's start bit begins the next cycle. Bit-level checker confirms every bit width is 434±0 cycles across both frames.

Source files
------------

// File: rtl/uart_mult_byte_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_mult_byte_tx
// Purpose  : Multi-byte UART packet transmitter (8N1, LSB first).
//            A request accepted in IDLE latches up to _MAX_BYTES payload
//            bytes. The block then sends one frame back-to-back on the
//            serial line: header byte, payload[0..len-1], CRC-8 trailer.
//            The CRC uses polynomial 0x07, init 0x00, no reflection and
//            no final XOR, and covers the payload only.
// Ports    : sys_clk    - system clock (single clock domain)
//            sys_rst_n  - asynchronous active-low reset
//            tx_start   - one-cycle request, sampled only in IDLE
//            tx_len     - payload byte count, clamped to _MAX_BYTES
//            tx_payload - payload, byte k at [8k+7:8k], byte 0 sent first
//            tx_busy    - high from the accepted request to the last stop bit
//            tx_done    - one-cycle pulse after the final stop bit
//            tx_crc     - CRC of the last frame, valid with tx_done
//            uart_txd   - serial output, idles high
// Revision : 1.0 - initial release
// ============================================================================
module uart_mult_byte_tx #(
    parameter int         CLK_FREQ   = 50_000_000,
    parameter int         UART_BPS   = 115200,
    parameter int         _MAX_BYTES = 11,
    parameter logic [7:0] _HEADER    = 8'hA5
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst_n,
    input  logic                    tx_start,
    input  logic [3:0]              tx_len,
    input  logic [_MAX_BYTES*8-1:0] tx_payload,
    output logic                    tx_busy,
    output logic                    tx_done,
    output logic [7:0]              tx_crc,
    output logic                    uart_txd
);

    // Bit period in clock cycles; integer division truncates.
    localparam int                BPS_CNT  = CLK_FREQ / UART_BPS;
    localparam int                CNT_W    = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BPS_CNT - 1);
    localparam logic [3:0]        MAX_LEN  = 4'(_MAX_BYTES);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] bit_cnt;     // cycles elapsed within the current bit
    logic [2:0]       bit_idx;     // data bit being sent, 0..7
    logic [3:0]       pay_idx;     // next payload byte to load, 0..len
    logic [3:0]       len;         // clamped payload length of this frame
    logic [7:0]       shift;       // byte on the wire, LSB in shift[0]
    logic [7:0]       crc;         // running CRC over loaded payload bytes
    logic             crc_phase;   // set while the CRC trailer is on the wire
    logic [7:0]       pay_bytes [_MAX_BYTES];

    wire bit_end = (bit_cnt == CNT_LAST);

    // Byte-wise CRC-8 update, MSB-first, polynomial x^8+x^2+x+1.
    function automatic logic [7:0] crc8_byte(input logic [7:0] c_in,
                                             input logic [7:0] d);
        logic [7:0] c;
        c = c_in ^ d;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction

    // Payload capture. The data path needs no reset because it is only
    // read after a request has loaded it.
    always_ff @(posedge sys_clk) begin
        if (state == IDLE && tx_start) begin
            for (int k = 0; k < _MAX_BYTES; k++) begin
                pay_bytes[k] <= tx_payload[8*k +: 8];
            end
        end
    end

    // Frame sequencer. All outputs are registered here.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            bit_idx   <= '0;
            pay_idx   <= '0;
            len       <= '0;
            shift     <= '0;
            crc       <= '0;
            crc_phase <= 1'b0;
            tx_busy   <= 1'b0;
            tx_done   <= 1'b0;
            tx_crc    <= '0;
            uart_txd  <= 1'b1;
        end else begin
            tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (tx_start) begin
                        len       <= (tx_len > MAX_LEN) ? MAX_LEN : tx_len;
                        crc       <= '0;
                        tx_crc    <= '0;
                        pay_idx   <= '0;
                        crc_phase <= 1'b0;
                        shift     <= _HEADER;
                        bit_cnt   <= '0;
                        bit_idx   <= '0;
                        uart_txd  <= 1'b0;
                        tx_busy   <= 1'b1;
                        state     <= START;
                    end
                end

                START: begin
                    if (bit_end) begin
                        bit_cnt  <= '0;
                        bit_idx  <= '0;
                        uart_txd <= shift[0];
                        state    <= DATA;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (bit_end) begin
                        bit_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            uart_txd <= 1'b1;
                            state    <= STOP;
                        end else begin
                            bit_idx  <= bit_idx + 1'b1;
                            shift    <= {1'b0, shift[7:1]};
                            uart_txd <= shift[1];
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end

                STOP: begin
                    if (bit_end) begin
                        bit_cnt <= '0;
                        if (crc_phase) begin
                            // Trailer finished: frame complete.
                            tx_busy <= 1'b0;
                            tx_done <= 1'b1;
                            tx_crc  <= crc;
                            state   <= DONE;
                        end else if (pay_idx < len) begin
                            // Next payload byte; fold it into the CRC as it
                            // is loaded so the trailer is ready in time.
                            shift    <= pay_bytes[pay_idx];
                            crc      <= crc8_byte(crc, pay_bytes[pay_idx]);
                            pay_idx  <= pay_idx + 1'b1;
                            uart_txd <= 1'b0;
                            state    <= START;
                        end else begin
                            shift     <= crc;
                            crc_phase <= 1'b1;
                            uart_txd  <= 1'b0;
                            state     <= START;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end

                DONE: begin
                    // A request seen here is dropped; only IDLE accepts.
                    state <= IDLE;
                end

                default: begin
                    state    <= IDLE;
                    tx_busy  <= 1'b0;
                    uart_txd <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_mult_byte_tx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_uart_mult_byte_tx
// Purpose  : Self-checking bench for uart_mult_byte_tx. Stimulus pushes the
//            expected line bytes and CRC into queues; a line decoder and a
//            done monitor pop and compare independently.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_mult_byte_tx;

    localparam int CLK_FREQ = 50_000_000;
    localparam int UART_BPS = 3_000_000;
    localparam int MAXB     = 11;
    localparam int BPS      = 16;   // 50e6 / 3e6 = 16.67, truncated

    logic              sys_clk    = 1'b0;
    logic              sys_rst_n  = 1'b0;
    logic              tx_start   = 1'b0;
    logic [3:0]        tx_len     = '0;
    logic [MAXB*8-1:0] tx_payload = '0;
    logic              tx_busy;
    logic              tx_done;
    logic [7:0]        tx_crc;
    logic              uart_txd;

    uart_mult_byte_tx #(
        .CLK_FREQ  (CLK_FREQ),
        .UART_BPS  (UART_BPS),
        ._MAX_BYTES(MAXB),
        ._HEADER   (8'hA5)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .tx_start  (tx_start),
        .tx_len    (tx_len),
        .tx_payload(tx_payload),
        .tx_busy   (tx_busy),
        .tx_done   (tx_done),
        .tx_crc    (tx_crc),
        .uart_txd  (uart_txd)
    );

    always #5 sys_clk = ~sys_clk;

    int         n_tests    = 0;
    int         n_fail     = 0;
    int         done_count = 0;
    logic [7:0] exp_q [$];
    logic [7:0] crc_q [$];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Serial reference CRC-8 (poly 0x07), fed one bit at a time MSB first.
    function automatic logic [7:0] crc_model(input logic [MAXB*8-1:0] pl,
                                             input int n);
        logic [7:0] c;
        logic       fb;
        c = 8'h00;
        for (int b = 0; b < n; b++) begin
            for (int i = 7; i >= 0; i--) begin
                fb = c[7] ^ pl[8*b + i];
                c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
            end
        end
        return c;
    endfunction

    // Receives one 10-bit character starting at the first low sample.
    // Every cycle of each bit must hold the same level.
    task automatic rx_byte(output bit fin, output logic [9:0] bits,
                           output bit clean);
        logic v;
        fin = 1'b0; clean = 1'b1; bits = '0; v = 1'b0;
        for (int k = 0; k < 10; k++) begin
            for (int c = 0; c < BPS; c++) begin
                if (k != 0 || c != 0) @(negedge sys_clk);
                if (!sys_rst_n) return;
                if (c == 0) begin
                    v       = uart_txd;
                    bits[k] = v;
                end else if (uart_txd !== v) begin
                    clean = 1'b0;
                end
            end
        end
        fin = 1'b1;
    endtask

    // Line monitor.
    initial begin : line_monitor
        bit         fin, clean;
        logic [9:0] bits;
        forever begin
            @(negedge sys_clk);
            if (sys_rst_n && uart_txd === 1'b0) begin
                rx_byte(fin, bits, clean);
                if (fin) begin
                    check("bit_width", {31'd0, clean}, 32'd1);
                    check("framing", {30'd0, bits[9], bits[0]}, 32'd2);
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_byte: got 0x%0h expected none",
                                 bits[8:1]);
                    end else begin
                        check("line_byte", {24'd0, bits[8:1]},
                              {24'd0, exp_q.pop_front()});
                    end
                end
            end
        end
    end

    // Done monitor.
    initial begin : done_monitor
        forever begin
            @(negedge sys_clk);
            if (sys_rst_n && tx_done === 1'b1) begin
                done_count++;
                if (crc_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_done: got tx_done=1 expected 0");
                end else begin
                    check("tx_crc", {24'd0, tx_crc}, {24'd0, crc_q.pop_front()});
                end
                check("busy_at_done", {31'd0, tx_busy}, 32'd0);
            end
        end
    end

    // Issues one request and follows it to completion. inject_at > 0 pulses a
    // different request that many cycles into the frame. With settle set, the
    // line is watched long enough for a spurious extra frame to surface.
    task automatic send_frame(input logic [3:0] len, input logic [MAXB*8-1:0] pl,
                              input logic [7:0] exp_crc, input int inject_at,
                              input bit settle);
        int nb, cnt, d0, limit;
        nb = (len > MAXB) ? MAXB : int'(len);
        exp_q.push_back(8'hA5);
        for (int i = 0; i < nb; i++) exp_q.push_back(pl[8*i +: 8]);
        exp_q.push_back(exp_crc);
        crc_q.push_back(exp_crc);
        @(negedge sys_clk);
        d0         = done_count;
        tx_len     = len;
        tx_payload = pl;
        tx_start   = 1'b1;
        @(negedge sys_clk);
        tx_start = 1'b0;
        check("busy_rise", {31'd0, tx_busy}, 32'd1);
        check("start_bit", {31'd0, uart_txd}, 32'd0);
        cnt   = 1;
        limit = (nb + 2) * 10 * BPS + 100;
        while (tx_busy === 1'b1 && cnt < limit) begin
            if (cnt == inject_at) begin
                tx_start   = 1'b1;
                tx_payload = ~pl;
                tx_len     = 4'd1;
            end else begin
                tx_start = 1'b0;
            end
            @(negedge sys_clk);
            cnt++;
        end
        tx_start = 1'b0;
        if (cnt >= limit) begin
            n_tests++;
            n_fail++;
            $display("FAIL busy_timeout: got busy after %0d cycles expected %0d",
                     cnt, (nb + 2) * 10 * BPS);
        end
        check("busy_cycles", cnt - 1, (nb + 2) * 10 * BPS);
        check("done_pulse", {31'd0, tx_done}, 32'd1);
        if (settle) begin
            repeat (12 * BPS) @(negedge sys_clk);
            check("queue_drained", exp_q.size(), 0);
            check("done_count", done_count - d0, 1);
            check("idle_busy", {31'd0, tx_busy}, 32'd0);
        end
    endtask

    initial begin : stimulus
        logic [MAXB*8-1:0] pl;
        int                bad, d0, seen;

        // Reset and idle line.
        repeat (5) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        check("reset_txd", {31'd0, uart_txd}, 32'd1);
        check("reset_busy", {31'd0, tx_busy}, 32'd0);
        check("reset_crc", {24'd0, tx_crc}, 32'd0);
        bad = 0;
        repeat (1000) begin
            @(negedge sys_clk);
            if (uart_txd !== 1'b1 || tx_busy !== 1'b0) bad++;
        end
        check("idle_1000", bad, 0);
        check("idle_no_done", done_count, 0);

        // Basic frame: A5 01 02 1B.
        pl = '0; pl[7:0] = 8'h01; pl[15:8] = 8'h02;
        send_frame(4'd2, pl, 8'h1B, 0, 1'b1);

        // CRC check value over "123456789".
        pl = '0;
        for (int k = 0; k < 9; k++) pl[8*k +: 8] = 8'h31 + 8'(k);
        send_frame(4'd9, pl, 8'hF4, 0, 1'b1);

        // Empty payload: A5 00, busy for 20 bit periods.
        send_frame(4'd0, '0, 8'h00, 0, 1'b1);

        // Request while busy is ignored and not queued.
        pl = '0; pl[7:0] = 8'hC3; pl[15:8] = 8'h5A; pl[23:16] = 8'hFF;
        send_frame(4'd3, pl, crc_model(pl, 3), 5 * BPS, 1'b1);

        // Length clamp: 15 requested, 11 sent.
        for (int k = 0; k < MAXB; k++) pl[8*k +: 8] = 8'h10 + 8'(k);
        send_frame(4'd15, pl, crc_model(pl, MAXB), 0, 1'b1);

        // Reset during DATA of payload byte 1.
        pl = '0; pl[7:0] = 8'h3C; pl[15:8] = 8'h81; pl[23:16] = 8'h99;
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h3C);
        @(negedge sys_clk);
        tx_len = 4'd3; tx_payload = pl; tx_start = 1'b1;
        @(negedge sys_clk);
        tx_start = 1'b0;
        repeat (24 * BPS + 2) @(negedge sys_clk);
        #2;
        sys_rst_n = 1'b0;
        #1;
        check("rst_txd_immediate", {31'd0, uart_txd}, 32'd1);
        check("rst_busy_immediate", {31'd0, tx_busy}, 32'd0);
        check("rst_bytes_before", exp_q.size(), 0);
        exp_q.delete();
        crc_q.delete();
        d0 = done_count;
        repeat (5) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (12 * BPS) @(negedge sys_clk);
        check("rst_no_done", done_count - d0, 0);
        check("rst_line_idle", {31'd0, uart_txd}, 32'd1);
        send_frame(4'd3, pl, crc_model(pl, 3), 0, 1'b1);

        // Back-to-back: request in the cycle after tx_done.
        pl = '0; pl[7:0] = 8'hAA; pl[15:8] = 8'h55;
        send_frame(4'd2, pl, crc_model(pl, 2), 0, 1'b0);
        pl = '0; pl[7:0] = 8'h80;
        send_frame(4'd1, pl, crc_model(pl, 1), 0, 1'b0);

        // Request in the DONE cycle is dropped.
        tx_len = 4'd1; tx_start = 1'b1;
        @(negedge sys_clk);
        tx_start = 1'b0;
        seen = 0;
        repeat (12 * BPS) begin
            @(negedge sys_clk);
            if (tx_busy !== 1'b0) seen++;
        end
        check("done_cycle_start_ignored", seen, 0);
        check("b2b_queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: got no completion expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
